gate_truth_sequencer: RTL and testbench
=======================================

Name: gate_truth_sequencer

Overview:
- Self-checking stimulus/response stage for the two-input basic-gate block.
- Drives the a,b operands through the full truth table and waits a settle interval per vector.
- Samples the 7 gate outputs, compares them to internally computed expected values, and accumulates mismatch statistics.
- Sits directly upstream of the gate block (feeds a,b) and consumes its outputs; replaces hand-written per-vector checks in bench and on-board self-test.

Parameters:
- SETTLE_CYCLES, 2, clocks to wait after driving a,b before sampling; 0 is legal (no wait).
- PASSES, 1, number of full 4-vector sweeps per run; minimum 1.
- CNT_W, 8, width of the mismatch counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a run; accepted only in IDLE
- a  out  1  operand A to gate block
- b  out  1  operand B to gate block
- gate_out  in  7  gate results {NOT a, AND, OR, NAND, NOR, XOR, XNOR}, bit 6 = NOT
- busy  out  1  high from the start-accept edge until DONE is left
- done  out  1  one-cycle pulse at end of run
- pass  out  1  1 if the last run had zero mismatches; held until the next accepted start
- err_cnt  out  CNT_W  mismatching samples in the current/last run, saturating
- fail_vec  out  7  sticky OR of per-bit mismatches for the current/last run

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (any time, including mid-run): state=IDLE; a=0, b=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0; vector index and pass index cleared.
- All outputs are registered.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 at an edge moves to DRIVE.
  - The same edge clears err_cnt, fail_vec, pass, vec_idx (2b) and pass_idx, and sets busy=1.
- DRIVE (1 cycle):
  - a<=vec_idx[1], b<=vec_idx[0]; load settle counter with SETTLE_CYCLES.
  - Next state is SETTLE, or SAMPLE if SETTLE_CYCLES=0.
- SETTLE: decrement the counter each cycle; after SETTLE_CYCLES cycles go to SAMPLE.
- SAMPLE (1 cycle):
  - exp = {~a, a&b, a|b, ~(a&b), ~(a|b), a^b, ~(a^b)}; diff = gate_out ^ exp.
  - If diff≠0: err_cnt += 1, saturating at 2^CNT_W−1; fail_vec |= diff.
  - If vec_idx<3: vec_idx++, go to DRIVE.
  - Else if pass_idx<PASSES−1: pass_idx++, vec_idx=0, go to DRIVE.
  - Else go to DONE.
- DONE (1 cycle):
  - done=1; pass<=(err_cnt==0), using err_cnt including the final sample.
  - Next edge: IDLE, busy=0, done=0.
- Vector order per pass: 00, 01, 10, 11.
- Run length: each vector takes SETTLE_CYCLES+2 cycles. done is high in cycle 4·PASSES·(SETTLE_CYCLES+2)+1 after the start-accept edge.
- a,b hold their last driven value in DONE and IDLE.
- start while busy (including in DONE) is ignored; no queuing.
- gate_out is only examined in SAMPLE; values in other states are don't-care.

Optional Feature:
- Macro: GATE_SEQ_STOP_ON_FAIL_EN.
- Defined: a SAMPLE with diff≠0 updates err_cnt/fail_vec and then goes directly to DONE (pass=0), regardless of remaining vectors or passes.
- Undefined: every vector of every pass is always sampled, as above.

Test Plan:
1. Defaults, ideal gate model, single start pulse → a,b = 00,01,10,11, each held 4 cycles; done pulse in cycle 17 after accept; pass=1, err_cnt=0, fail_vec=0.
2. XOR output (bit 1) stuck at 0 → mismatches at 01 and 10; err_cnt=2, fail_vec=7'b0000010, pass=0.
3. PASSES=3, CNT_W=2, NOT output stuck at 1 → 2 mismatches per pass; err_cnt saturates at 3, fail_vec=7'b1000000, done in cycle 49.
4. start held high through a whole run, plus a second pulse during DONE → one run only; start in IDLE the following cycle begins a new run with err_cnt, fail_vec and pass cleared.
5. rst_n asserted low while a,b=10 during SETTLE → same cycle: busy=0, a=b=0, err_cnt=0, fail_vec=0; no done pulse after release.
6. GATE_SEQ_STOP_ON_FAIL_EN defined, AND output stuck at 1 → mismatch at vector 00; done in cycle 5, err_cnt=1, fail_vec=7'b0100000, pass=0.

Source files
------------

// File: rtl/gate_truth_sequencer.sv
// gate_truth_sequencer
// Walks the operand pair (a,b) through 00, 01, 10, 11, waits a settle interval
// per vector, samples the 7 gate outputs and compares them with the expected
// truth table. Mismatch count and a sticky per-bit fail vector are kept per run.
// Optional build macro: GATE_SEQ_STOP_ON_FAIL_EN (end the run at the first mismatch).
module gate_truth_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic [6:0]       gate_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [6:0]       fail_vec
);

    localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [6:0]       fail_q, fail_d;
    logic [1:0]       vec_q, vec_d;
    logic [PW-1:0]    pidx_q, pidx_d;
    logic [SW-1:0]    cnt_q, cnt_d;

    logic [6:0]       exp_vec;
    logic [6:0]       diff;
    logic             last_vec;

    // Expected gate results for the operands currently driven, and the per-bit mismatch.
    always_comb begin
        exp_vec  = {~a_q, a_q & b_q, a_q | b_q, ~(a_q & b_q), ~(a_q | b_q), a_q ^ b_q, ~(a_q ^ b_q)};
        diff     = gate_out ^ exp_vec;
        last_vec = (vec_q == 2'd3) && (pidx_q == PW'(PASSES - 1));
    end

    // Next-state and next-output computation for the sequencer FSM.
    always_comb begin
        // NOTE: every *_d gets its hold value first, so no path leaves a variable
        // unassigned and no latch is inferred.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        fail_d  = fail_q;
        vec_d   = vec_q;
        pidx_d  = pidx_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_DRIVE;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fail_d  = '0;
                    vec_d   = '0;
                    pidx_d  = '0;
                end
            end
            S_DRIVE: begin
                a_d     = vec_q[1];
                b_d     = vec_q[0];
                cnt_d   = SW'(SETTLE_CYCLES);
                state_d = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
            end
            S_SETTLE: begin
                cnt_d = cnt_q - SW'(1);
                if (cnt_q == SW'(1)) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (diff != 7'd0) begin
                    if (err_q != {CNT_W{1'b1}}) begin
                        err_d = err_q + CNT_W'(1);
                    end
                    fail_d = fail_q | diff;
                end
                if (last_vec || (STOP_ON_FAIL && (diff != 7'd0))) begin
                    // done and pass are raised on entry to DONE so they are visible
                    // during the DONE cycle; pass already includes this final sample.
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else if (vec_q != 2'd3) begin
                    vec_d   = vec_q + 2'd1;
                    state_d = S_DRIVE;
                end else begin
                    vec_d   = 2'd0;
                    pidx_d  = pidx_q + PW'(1);
                    state_d = S_DRIVE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset returns everything to the idle values.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
            vec_q   <= '0;
            pidx_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            vec_q   <= vec_d;
            pidx_q  <= pidx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign a        = a_q;
    assign b        = b_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = err_q;
    assign fail_vec = fail_q;

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Testbench for gate_truth_sequencer: three instances (defaults, PASSES=3/CNT_W=2,
// SETTLE_CYCLES=0) each fed by a gate model with programmable stuck-at faults.
module tb_gate_truth_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start    [3];
    logic [6:0] gate_out [3];
    logic       a_o      [3];
    logic       b_o      [3];
    logic       busy_o   [3];
    logic       done_o   [3];
    logic       pass_o   [3];
    logic [6:0] fail_o   [3];
    logic [6:0] sa0      [3];
    logic [6:0] sa1      [3];
    logic [7:0] err0;
    logic [1:0] err1;
    logic [7:0] err2;
    logic [1:0] ablog [0:127];

    int n_checks = 0;
    int n_errors = 0;

    gate_truth_sequencer u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .a(a_o[0]), .b(b_o[0]),
        .gate_out(gate_out[0]), .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
        .err_cnt(err0), .fail_vec(fail_o[0])
    );

    gate_truth_sequencer #(.PASSES(3), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .a(a_o[1]), .b(b_o[1]),
        .gate_out(gate_out[1]), .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
        .err_cnt(err1), .fail_vec(fail_o[1])
    );

    gate_truth_sequencer #(.SETTLE_CYCLES(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .a(a_o[2]), .b(b_o[2]),
        .gate_out(gate_out[2]), .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]),
        .err_cnt(err2), .fail_vec(fail_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ideal(input logic ia, input logic ib);
        return {~ia, ia & ib, ia | ib, ~(ia & ib), ~(ia | ib), ia ^ ib, ~(ia ^ ib)};
    endfunction

    // Gate block model with stuck-at-0 / stuck-at-1 masks.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            gate_out[i] = (ideal(a_o[i], b_o[i]) & ~sa0[i]) | sa1[i];
        end
    end

    function automatic logic [31:0] get_err(input int d);
        case (d)
            0:       return 32'(err0);
            1:       return 32'(err1);
            default: return 32'(err2);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Accept a start pulse on instance d, log a,b per cycle, and find the done cycle.
    // Returns three cycles after done (instance back in IDLE) or at the limit.
    task automatic run(input int d, input int limit, output int done_cyc, output int n_done);
        @(negedge clk);
        start[d] = 1'b1;
        @(posedge clk);
        #1;
        start[d] = 1'b0;
        check("accept_busy", 32'(busy_o[d]), 1);
        check("accept_err_clear", get_err(d), 0);
        check("accept_fail_clear", 32'(fail_o[d]), 0);
        check("accept_pass_clear", 32'(pass_o[d]), 0);
        done_cyc = -1;
        n_done   = 0;
        for (int k = 1; k <= limit; k++) begin
            ablog[k] = {a_o[d], b_o[d]};
            if (done_o[d]) begin
                n_done++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (done_cyc > 0 && k >= done_cyc + 3) break;
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        string      name;
        logic [6:0] f0;
        logic [6:0] f1;
        int         err;
        logic [6:0] fail;
        int         done_cyc;
    } vec_t;

    vec_t tbl[6];
    int   dc;
    int   nd;
    int   k;

    initial begin
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
        tbl[0] = '{"ideal",     7'h00,        7'h00,        0, 7'b0000000, 17};
        tbl[1] = '{"xor_sa0",   7'b0000010,   7'h00,        1, 7'b0000010,  9};
        tbl[2] = '{"not_sa1",   7'h00,        7'b1000000,   1, 7'b1000000, 13};
        tbl[3] = '{"and_sa1",   7'h00,        7'b0100000,   1, 7'b0100000,  5};
        tbl[4] = '{"all_sa1",   7'h00,        7'b1111111,   1, 7'b0110010,  5};
        tbl[5] = '{"xnor_sa0",  7'b0000001,   7'h00,        1, 7'b0000001,  5};
`else
        tbl[0] = '{"ideal",     7'h00,        7'h00,        0, 7'b0000000, 17};
        tbl[1] = '{"xor_sa0",   7'b0000010,   7'h00,        2, 7'b0000010, 17};
        tbl[2] = '{"not_sa1",   7'h00,        7'b1000000,   2, 7'b1000000, 17};
        tbl[3] = '{"and_sa1",   7'h00,        7'b0100000,   3, 7'b0100000, 17};
        tbl[4] = '{"all_sa1",   7'h00,        7'b1111111,   4, 7'b1111111, 17};
        tbl[5] = '{"xnor_sa0",  7'b0000001,   7'h00,        2, 7'b0000001, 17};
`endif
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            sa0[i]   = 7'h00;
            sa1[i]   = 7'h00;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_a", 32'(a_o[0]), 0);
        check("rst_b", 32'(b_o[0]), 0);
        check("rst_busy", 32'(busy_o[0]), 0);
        check("rst_done", 32'(done_o[0]), 0);
        check("rst_pass", 32'(pass_o[0]), 0);
        check("rst_err", get_err(0), 0);
        check("rst_fail", 32'(fail_o[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Ideal gate, defaults: vector timing and a,b sequence.
        run(0, 100, dc, nd);
        check("t1_done_cycle", 32'(dc), 17);
        check("t1_done_once", 32'(nd), 1);
        for (int c = 2; c <= 16; c++) begin
            check("t1_ab_seq", 32'(ablog[c]), 32'((c - 2) / 4));
        end
        check("t1_ab_hold_done", 32'(ablog[17]), 3);
        check("t1_pass", 32'(pass_o[0]), 1);
        check("t1_busy_low", 32'(busy_o[0]), 0);
        check("t1_ab_hold_idle", 32'({a_o[0], b_o[0]}), 3);

        // Fault table on the default instance.
        for (int t = 0; t < 6; t++) begin
            sa0[0] = tbl[t].f0;
            sa1[0] = tbl[t].f1;
            run(0, 100, dc, nd);
            check({tbl[t].name, "_done_cycle"}, 32'(dc), 32'(tbl[t].done_cyc));
            check({tbl[t].name, "_done_once"}, 32'(nd), 1);
            check({tbl[t].name, "_err"}, get_err(0), 32'(tbl[t].err));
            check({tbl[t].name, "_fail_vec"}, 32'(fail_o[0]), 32'(tbl[t].fail));
            check({tbl[t].name, "_pass"}, 32'(pass_o[0]), 32'(tbl[t].err == 0));
            check({tbl[t].name, "_busy_low"}, 32'(busy_o[0]), 0);
        end
        sa0[0] = 7'h00;
        sa1[0] = 7'h00;

        // Three passes, 2-bit counter, NOT stuck at 1: counter saturates.
        sa1[1] = 7'b1000000;
        run(1, 120, dc, nd);
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
        check("t3_done_cycle", 32'(dc), 13);
        check("t3_err", get_err(1), 1);
`else
        check("t3_done_cycle", 32'(dc), 49);
        check("t3_err_sat", get_err(1), 3);
`endif
        check("t3_fail_vec", 32'(fail_o[1]), 32'(7'b1000000));
        check("t3_pass", 32'(pass_o[1]), 0);
        sa1[1] = 7'h00;

        // Zero settle cycles: two cycles per vector.
        run(2, 100, dc, nd);
        check("s0_done_cycle", 32'(dc), 9);
        for (int v = 0; v < 4; v++) begin
            check("s0_ab_sample", 32'(ablog[2 * v + 2]), 32'(v));
            check("s0_ab_hold", 32'(ablog[2 * v + 3]), 32'(v));
        end
        check("s0_pass", 32'(pass_o[2]), 1);

        // start held high through a whole run, including DONE: only one run.
        sa1[0] = 7'b1111111;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        k  = 1;
        dc = -1;
        while (k <= 60 && dc < 0) begin
            if (done_o[0]) begin
                dc = k;
            end else begin
                @(posedge clk);
                #1;
                k++;
            end
        end
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
        check("t4_done_cycle", 32'(dc), 5);
`else
        check("t4_done_cycle", 32'(dc), 17);
`endif
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        nd = 0;
        for (int c = 0; c < 4; c++) begin
            if (done_o[0] || busy_o[0]) nd++;
            @(posedge clk);
            #1;
        end
        check("t4_no_rerun", 32'(nd), 0);
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
        check("t4_err_kept", get_err(0), 1);
`else
        check("t4_err_kept", get_err(0), 4);
`endif
        sa1[0] = 7'h00;
        run(0, 100, dc, nd);
        check("t4_rerun_done", 32'(dc), 17);
        check("t4_rerun_pass", 32'(pass_o[0]), 1);

        // Asynchronous reset during SETTLE of vector 10.
`ifndef GATE_SEQ_STOP_ON_FAIL_EN
        sa0[0] = 7'b0000010;
`endif
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        check("t5_pre_ab", 32'({a_o[0], b_o[0]}), 2);
        check("t5_pre_busy", 32'(busy_o[0]), 1);
`ifndef GATE_SEQ_STOP_ON_FAIL_EN
        check("t5_pre_err", get_err(0), 1);
`endif
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", 32'(busy_o[0]), 0);
        check("t5_rst_ab", 32'({a_o[0], b_o[0]}), 0);
        check("t5_rst_err", get_err(0), 0);
        check("t5_rst_fail", 32'(fail_o[0]), 0);
        check("t5_rst_done", 32'(done_o[0]), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        sa0[0] = 7'h00;
        nd = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (done_o[0] || busy_o[0]) nd++;
        end
        check("t5_no_done_after", 32'(nd), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
